fft_ram_writer: RTL and testbench

Producer side of the channel FFT RAM. Accepts a stream of complex samples and saturates each component to 14 bits. Writes each sample as a 28-bit word {real, imag} at the bit-reversed frame index, so a reader sweeping linear addresses sees bit-reversed order. After a full 1024-word frame it raises `fftdone` and holds the RAM stable until the reader returns `detectdone`, then re-arms for the next frame.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/sat_clip.sv | 26 ++
 rtl/fft_ram_writer.sv | 93 +++++++++
 tb/tb_fft_ram_writer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the channel FFT RAM producer and reader.
package fft_pkg;

  localparam int FFT_ADDR_W = 10;
  localparam int FFT_N      = 1 << FFT_ADDR_W;
  localparam int FFT_COMP_W = 14;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_LAST    = 2'd1,
    ST_DONE    = 2'd2,
    ST_RELEASE = 2'd3
  } wr_state_t;

  // Reverses the low w bits of v; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_clip.sv
// Signed saturator: narrows IN_W to OUT_W, clamping to the OUT_W range.
module sat_clip #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 14
) (
  input  logic signed [IN_W-1:0]  din,
  output logic        [OUT_W-1:0] dout,
  output logic                    clipped
);

  // Value fits iff every bit from the OUT_W sign bit upward matches.
  logic [IN_W-OUT_W:0] top;

  assign top     = din[IN_W-1:OUT_W-1];
  assign clipped = !((top == '0) || (top == '1));

  always_comb begin
    if (!clipped)
      dout = din[OUT_W-1:0];
    else if (din[IN_W-1])
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    else
      dout = {1'b0, {(OUT_W-1){1'b1}}};
  end

endmodule

// File: rtl/fft_ram_writer.sv
// Writes saturated complex samples into the FFT RAM in bit-reversed order
// and hands each complete frame to the reader via fftdone/detectdone.
module fft_ram_writer
  import fft_pkg::*;
#(
  parameter int ADDR_W = FFT_ADDR_W,
  parameter int IN_W   = 16,
  parameter int OUT_W  = FFT_COMP_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_real,
  input  logic signed [IN_W-1:0]  in_imag,
  input  logic                    detectdone,
  output logic [ADDR_W-1:0]       ramaddr,
  output logic [2*OUT_W-1:0]      ramdata,
  output logic                    ramwe,
  output logic                    fftdone,
  output logic                    satflag
);

  localparam logic [1:0] FILL    = ST_FILL;
  localparam logic [1:0] LAST    = ST_LAST;
  localparam logic [1:0] DONE    = ST_DONE;
  localparam logic [1:0] RELEASE = ST_RELEASE;

  logic [1:0]        state;
  logic [ADDR_W-1:0] count;
  logic [OUT_W-1:0]  sat_re;
  logic [OUT_W-1:0]  sat_im;
  logic              clip_re;
  logic              clip_im;
  logic              accept;

  sat_clip #(.IN_W(IN_W), .OUT_W(OUT_W)) u_sat_re (
    .din     (in_real),
    .dout    (sat_re),
    .clipped (clip_re)
  );

  sat_clip #(.IN_W(IN_W), .OUT_W(OUT_W)) u_sat_im (
    .din     (in_imag),
    .dout    (sat_im),
    .clipped (clip_im)
  );

  // Handshake outputs depend on the state register only.
  assign in_ready = (state == FILL);
  assign fftdone  = (state == DONE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FILL;
      count   <= '0;
      ramaddr <= '0;
      ramdata <= '0;
      ramwe   <= 1'b0;
      satflag <= 1'b0;
    end else begin
      ramwe <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            ramaddr <= ADDR_W'(bitrev(32'(count), ADDR_W));
            ramdata <= {sat_re, sat_im};
            ramwe   <= 1'b1;
            count   <= count + 1'b1;
            if (clip_re || clip_im) satflag <= 1'b1;
            if (count == '1) state <= LAST;
          end
        end
        LAST: state <= DONE;
        DONE: begin
          if (detectdone) state <= RELEASE;
        end
        RELEASE: begin
          // The flag covers the frame just handed over, so it survives
          // until the reader lets go and the next frame begins.
          if (!detectdone) begin
            state   <= FILL;
            count   <= '0;
            satflag <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_ram_writer.sv
// Directed-plus-random bench for fft_ram_writer with a frame-level model.
module tb_fft_ram_writer;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_real;
  logic signed [15:0] in_imag;
  logic               detectdone;
  logic [9:0]         ramaddr;
  logic [27:0]        ramdata;
  logic               ramwe;
  logic               fftdone;
  logic               satflag;

  int total = 0;
  int bad   = 0;

  // Model of the frame: next index, whether samples are taken, sticky clip.
  int m_cnt;
  bit m_fill;
  bit m_sat;
  int writes;
  bit seen [1024];

  fft_ram_writer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_real    (in_real),
    .in_imag    (in_imag),
    .detectdone (detectdone),
    .ramaddr    (ramaddr),
    .ramdata    (ramdata),
    .ramwe      (ramwe),
    .fftdone    (fftdone),
    .satflag    (satflag)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rev10(input int c);
    int r = 0;
    for (int b = 0; b < 10; b++)
      if (((c >> b) & 1) != 0) r += 1 << (9 - b);
    return r;
  endfunction

  function automatic int sat_i(input int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  function automatic int rnd_full();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic int rnd_small();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  task automatic new_frame();
    m_cnt  = 0;
    m_fill = 1'b1;
    m_sat  = 1'b0;
    writes = 0;
    for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
  endtask

  // One clock: drive a sample, then check the registered write against the model.
  task automatic step(input bit v, input int re, input int im);
    bit acc;
    logic [13:0] er, ei;
    in_valid = v;
    in_real  = 16'(re);
    in_imag  = 16'(im);
    acc = v && m_fill;
    @(posedge clk); #1;
    if (acc) begin
      er = 14'(sat_i(re));
      ei = 14'(sat_i(im));
      chk("ramwe", 32'(ramwe), 32'd1);
      chk("ramaddr", 32'(ramaddr), 32'(rev10(m_cnt)));
      chk("ramdata", 32'(ramdata), 32'({er, ei}));
      chk("addr_dup", 32'(seen[ramaddr]), 32'd0);
      seen[ramaddr] = 1'b1;
      if (sat_i(re) != re || sat_i(im) != im) m_sat = 1'b1;
      m_cnt++;
      writes++;
      if (m_cnt == 1024) m_fill = 1'b0;
    end else begin
      chk("ramwe_idle", 32'(ramwe), 32'd0);
    end
    chk("satflag", 32'(satflag), 32'(m_sat));
    chk("in_ready", 32'(in_ready), 32'(m_fill));
    chk("fftdone_fill", 32'(fftdone), 32'd0);
    in_valid = 1'b0;
  endtask

  // Called with the final write on the bus; walks DONE/RELEASE back to FILL.
  task automatic finish_frame(input bit dd_early);
    @(posedge clk); #1;
    chk("fftdone_rise", 32'(fftdone), 32'd1);
    chk("done_ramwe", 32'(ramwe), 32'd0);
    chk("done_ready", 32'(in_ready), 32'd0);
    chk("done_sat", 32'(satflag), 32'(m_sat));
    if (!dd_early) begin
      for (int i = 0; i < 100; i++) begin
        in_valid = 1'b1;
        in_real  = 16'(rnd_small());
        @(posedge clk); #1;
        chk("hold_done", 32'(fftdone), 32'd1);
        chk("hold_ready", 32'(in_ready), 32'd0);
        chk("hold_ramwe", 32'(ramwe), 32'd0);
      end
      in_valid   = 1'b0;
      detectdone = 1'b1;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    chk("release_done", 32'(fftdone), 32'd0);
    chk("release_ready", 32'(in_ready), 32'd0);
    chk("release_sat", 32'(satflag), 32'(m_sat));
    $display("handshake: fftdone dropped (early=%0d)", dd_early);
    detectdone = 1'b0;
    @(posedge clk); #1;
    chk("rearm_ready", 32'(in_ready), 32'd1);
    chk("rearm_done", 32'(fftdone), 32'd0);
    chk("rearm_sat", 32'(satflag), 32'd0);
    new_frame();
  endtask

  initial begin
    int cyc;
    int nseen;
    int bnd [6] = '{8191, 8192, -8192, -8193, 32767, -32768};

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_real    = '0;
    in_imag    = '0;
    detectdone = 1'b0;
    new_frame();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) step(1'b0, 0, 0);
    chk("idle_ramaddr", 32'(ramaddr), 32'd0);
    chk("idle_ramdata", 32'(ramdata), 32'd0);
    $display("reset/idle checked");

    // Frame A: ramp, back-to-back, long reader hold.
    for (int i = 0; i < 1024; i++) begin
      step(1'b1, i, -i);
      if (i == 1) begin
        chk("s1_addr", 32'(ramaddr), 32'd512);
        chk("s1_data", 32'(ramdata), 32'h0007FFF);
      end
      if (i == 1023) chk("s1023_addr", 32'(ramaddr), 32'd1023);
    end
    $display("frame A: %0d writes", writes);
    finish_frame(1'b0);

    // Frame B: clip first sample, 50% gaps, detectdone high throughout.
    detectdone = 1'b1;
    step(1'b1, 32767, -32768);
    chk("clip_addr0", 32'(ramaddr), 32'd0);
    chk("clip_data", 32'(ramdata), 32'h7FFE000);
    chk("clip_flag", 32'(satflag), 32'd1);
    cyc = 0;
    while (m_fill && cyc < 6000) begin
      step(1'($urandom_range(0, 1)), rnd_small(), rnd_small());
      cyc++;
    end
    chk("gap_writes", 32'(writes), 32'd1024);
    nseen = 0;
    for (int i = 0; i < 1024; i++) nseen += int'(seen[i]);
    chk("gap_perm", 32'(nseen), 32'd1024);
    $display("frame B: %0d writes in %0d gapped cycles", writes, cyc);
    finish_frame(1'b1);

    // Frame C: aborted by reset after 500 accepts.
    for (int i = 0; i < 500; i++) step(1'b1, rnd_full(), rnd_full());
    in_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_ramwe", 32'(ramwe), 32'd0);
    chk("rst_ramaddr", 32'(ramaddr), 32'd0);
    chk("rst_ramdata", 32'(ramdata), 32'd0);
    chk("rst_fftdone", 32'(fftdone), 32'd0);
    chk("rst_satflag", 32'(satflag), 32'd0);
    @(posedge clk); #1;
    chk("rst_nowrite", 32'(ramwe), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    new_frame();
    $display("frame C: reset after 500 accepts");

    // Frame D: saturation boundaries, then full-range random values.
    for (int i = 0; i < 1024; i++) begin
      if (i < 6) step(1'b1, bnd[i], bnd[5 - i]);
      else step(1'b1, rnd_full(), rnd_full());
      if (i == 0) chk("d_first_addr", 32'(ramaddr), 32'd0);
    end
    $display("frame D: %0d writes", writes);
    finish_frame(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
